// File: rtl/imem_program_loader.sv
// imem_program_loader
// Accepts symbolic instructions (mnemonic plus physical register numbers) and
// range-checks each one. Legal instructions are encoded into 9-bit machine
// words and written to consecutive instruction-memory addresses starting at
// base_addr. Loading stops after HALT, after an illegal instruction, or when
// the last memory address has been written. Addresses never wrap.
module imem_program_loader #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_mnem,
   input  logic [3:0]         in_rs,
   input  logic [3:0]         in_rt,
   input  logic [3:0]         in_rd,
   input  logic [2:0]         in_imm,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code,
   output logic [ADDR_W:0]    count
);

   localparam logic [3:0] M_AND  = 4'd0;
   localparam logic [3:0] M_SLT  = 4'd1;
   localparam logic [3:0] M_OR   = 4'd2;
   localparam logic [3:0] M_JR   = 4'd3;
   localparam logic [3:0] M_LW   = 4'd4;
   localparam logic [3:0] M_SW   = 4'd5;
   localparam logic [3:0] M_ADD  = 4'd6;
   localparam logic [3:0] M_ADDI = 4'd7;
   localparam logic [3:0] M_TR   = 4'd8;
   localparam logic [3:0] M_HALT = 4'd9;

   localparam logic [1:0] E_NONE    = 2'd0;
   localparam logic [1:0] E_ILLEGAL = 2'd1;
   localparam logic [1:0] E_BADMNEM = 2'd2;
   localparam logic [1:0] E_FULL    = 2'd3;

   localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

   state_t              state_q, state_d;
   logic [1:0]          code_q, code_d;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W:0]     count_q;
   logic [ADDR_W:0]     wr_addr;
   logic                xfer;
   logic                start_acc;
   logic                wr_d;
   logic                vld_p1;
   logic [ADDR_W-1:0]   addr_p1;
   logic [INSTR_W-1:0]  wdata_p1;

   // Field range check; a register field only matters if the mnemonic uses it.
   function automatic logic field_legal(input logic [3:0] mnem, input logic [3:0] rs,
                                        input logic [3:0] rt, input logic [3:0] rd,
                                        input logic [2:0] imm);
      logic rs_hi, rt_lo;
      rs_hi = (rs[3:2] == 2'b01);   // 4..7
      rt_lo = (rt[3:2] == 2'b00);   // 0..3
      case (mnem)
         M_AND, M_SLT, M_OR, M_JR, M_LW, M_SW: return rs_hi && rt_lo;
         M_ADD:  return rs_hi && rt_lo && (rd[3:2] == 2'b10);
         M_ADDI: return rs_hi && (rd[3:2] == 2'b00) && !imm[2];
         M_TR:   return !rs[3] && !rt[3];
         M_HALT: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Machine-word encoding; rs-4 and rd-8 reduce to the low two bits once legal.
   function automatic logic [INSTR_W-1:0] encode(input logic [3:0] mnem, input logic [3:0] rs,
                                                 input logic [3:0] rt, input logic [3:0] rd,
                                                 input logic [2:0] imm);
      case (mnem)
         M_AND, M_SLT, M_OR, M_JR: return {3'b000, rs[1:0], rt[1:0], mnem[1:0]};
         M_LW, M_SW:               return {3'b001, rs[1:0], rt[1:0], 1'b0, (mnem == M_SW)};
         M_ADD:                    return {3'b010, rs[1:0], rt[1:0], rd[1:0]};
         M_ADDI:                   return {3'b011, rs[1:0], imm[1:0], rd[1:0]};
         M_TR:                     return {3'b100, rs[2:0], rt[2:0]};
         M_HALT:                   return 9'h1C0;
         default:                  return '0;
      endcase
   endfunction

   assign xfer    = in_valid && (state_q == S_LOAD);
   assign wr_addr = {1'b0, base_q} + count_q;

   // State and sticky error-code register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         code_q  <= E_NONE;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
      end
   end

   // Next state: start outside LOAD restarts; each transfer may write, terminate, or both.
   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      wr_d      = 1'b0;
      start_acc = 1'b0;
      case (state_q)
         S_LOAD: begin
            if (xfer) begin
               if (in_mnem > M_HALT) begin
                  state_d = S_ERR;
                  code_d  = E_BADMNEM;
               end else if (!field_legal(in_mnem, in_rs, in_rt, in_rd, in_imm)) begin
                  state_d = S_ERR;
                  code_d  = E_ILLEGAL;
               end else begin
                  wr_d = 1'b1;
                  if (in_mnem == M_HALT) begin
                     state_d = S_DONE;
                  end else if (wr_addr == LAST_ADDR) begin
                     state_d = S_ERR;
                     code_d  = E_FULL;
                  end
               end
            end
         end
         default: begin
            if (start) begin
               state_d   = S_LOAD;
               code_d    = E_NONE;
               start_acc = 1'b1;
            end
         end
      endcase
   end

   // Write stage: one registered imem write per accepted legal word; count tracks writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         addr_p1  <= '0;
         wdata_p1 <= '0;
         count_q  <= '0;
         base_q   <= '0;
      end else begin
         vld_p1 <= wr_d;
         if (wr_d) begin
            addr_p1  <= wr_addr[ADDR_W-1:0];
            wdata_p1 <= encode(in_mnem, in_rs, in_rt, in_rd, in_imm);
            count_q  <= count_q + 1'b1;
         end else if (start_acc) begin
            base_q  <= base_addr;
            count_q <= '0;
         end
      end
   end

   // Status outputs decoded from the current state.
   always_comb begin
      in_ready = (state_q == S_LOAD);
      busy     = (state_q == S_LOAD);
      done     = (state_q == S_DONE);
      err      = (state_q == S_ERR);
   end

   assign imem_we    = vld_p1;
   assign imem_addr  = addr_p1;
   assign imem_wdata = wdata_p1;
   assign err_code   = code_q;
   assign count      = count_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Testbench for imem_program_loader: single-instruction vector table plus
// directed multi-cycle sequences (back-to-back load, restart, memory full,
// reset during a transfer). A second instance with ADDR_W=2 covers the end
// of memory.
module tb_imem_program_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   // Main instance (ADDR_W = 8)
   logic       start = 1'b0;
   logic [7:0] base_addr = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0;
   logic [2:0] in_imm = '0;
   logic       imem_we;
   logic [7:0] imem_addr;
   logic [8:0] imem_wdata;
   logic       busy, done, err;
   logic [1:0] err_code;
   logic [8:0] count;

   // Small instance (ADDR_W = 2)
   logic       s_start = 1'b0;
   logic [1:0] s_base_addr = '0;
   logic       s_in_valid = 1'b0;
   logic       s_in_ready;
   logic [3:0] s_in_mnem = '0, s_in_rs = '0, s_in_rt = '0, s_in_rd = '0;
   logic [2:0] s_in_imm = '0;
   logic       s_imem_we;
   logic [1:0] s_imem_addr;
   logic [8:0] s_imem_wdata;
   logic       s_busy, s_done, s_err;
   logic [1:0] s_err_code;
   logic [2:0] s_count;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   imem_program_loader #(.ADDR_W(8), .INSTR_W(9)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .err(err), .err_code(err_code), .count(count)
   );

   imem_program_loader #(.ADDR_W(2), .INSTR_W(9)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(s_start), .base_addr(s_base_addr),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_mnem(s_in_mnem),
      .in_rs(s_in_rs), .in_rt(s_in_rt), .in_rd(s_in_rd), .in_imm(s_in_imm),
      .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
      .busy(s_busy), .done(s_done), .err(s_err), .err_code(s_err_code), .count(s_count)
   );

   typedef struct {
      logic [3:0] mnem;
      logic [3:0] rs;
      logic [3:0] rt;
      logic [3:0] rd;
      logic [2:0] imm;
      logic       we;
      logic [8:0] wdata;
      logic       done;
      logic       err;
      logic [1:0] code;
   } vec_t;

   localparam int NV = 19;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic start_load(input logic [7:0] b);
      base_addr = b;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic set_in(input logic [3:0] m, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] rd, input logic [2:0] imm);
      in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
   endtask

   initial begin
      // mnem rs rt rd imm | we wdata done err code
      tbl[0]  = '{4'd6, 4'd5, 4'd2, 4'd9,  3'd0, 1'b1, 9'h099, 1'b0, 1'b0, 2'd0}; // ADD
      tbl[1]  = '{4'd0, 4'd4, 4'd3, 4'd0,  3'd0, 1'b1, 9'h00C, 1'b0, 1'b0, 2'd0}; // AND
      tbl[2]  = '{4'd1, 4'd7, 4'd0, 4'd0,  3'd0, 1'b1, 9'h031, 1'b0, 1'b0, 2'd0}; // SLT {000,11,00,01}
      tbl[3]  = '{4'd2, 4'd6, 4'd1, 4'd0,  3'd0, 1'b1, 9'h026, 1'b0, 1'b0, 2'd0}; // OR  {000,10,01,10}
      tbl[4]  = '{4'd3, 4'd5, 4'd2, 4'd15, 3'd7, 1'b1, 9'h01B, 1'b0, 1'b0, 2'd0}; // JR  {000,01,10,11}
      tbl[5]  = '{4'd4, 4'd4, 4'd1, 4'd0,  3'd0, 1'b1, 9'h044, 1'b0, 1'b0, 2'd0}; // LW  {001,00,01,00}
      tbl[6]  = '{4'd5, 4'd6, 4'd1, 4'd0,  3'd0, 1'b1, 9'h065, 1'b0, 1'b0, 2'd0}; // SW  {001,10,01,01}
      tbl[7]  = '{4'd7, 4'd7, 4'd9, 4'd1,  3'd2, 1'b1, 9'h0F9, 1'b0, 1'b0, 2'd0}; // ADDI, rt unused
      tbl[8]  = '{4'd8, 4'd3, 4'd6, 4'd15, 3'd7, 1'b1, 9'h11E, 1'b0, 1'b0, 2'd0}; // TR
      tbl[9]  = '{4'd9, 4'd15,4'd15,4'd15, 3'd7, 1'b1, 9'h1C0, 1'b1, 1'b0, 2'd0}; // HALT
      tbl[10] = '{4'd6, 4'd5, 4'd2, 4'd3,  3'd0, 1'b0, 9'h000, 1'b0, 1'b1, 2'd1}; // ADD rd=3
      tbl[11] = '{4'd0, 4'd3, 4'd0, 4'd0,  3'd0, 1'b0, 9'h000, 1'b0, 1'b1, 2'd1}; // AND rs=3
      tbl[12] = '{4'd0, 4'd4, 4'd4, 4'd0,  3'd0, 1'b0, 9'h000, 1'b0, 1'b1, 2'd1}; // AND rt=4
      tbl[13] = '{4'd7, 4'd4, 4'd0, 4'd0,  3'd5, 1'b0, 9'h000, 1'b0, 1'b1, 2'd1}; // ADDI imm=5
      tbl[14] = '{4'd7, 4'd4, 4'd0, 4'd4,  3'd1, 1'b0, 9'h000, 1'b0, 1'b1, 2'd1}; // ADDI rd=4
      tbl[15] = '{4'd8, 4'd8, 4'd0, 4'd0,  3'd0, 1'b0, 9'h000, 1'b0, 1'b1, 2'd1}; // TR rs=8
      tbl[16] = '{4'd12,4'd4, 4'd0, 4'd8,  3'd0, 1'b0, 9'h000, 1'b0, 1'b1, 2'd2}; // bad mnem 12
      tbl[17] = '{4'd15,4'd4, 4'd0, 4'd8,  3'd0, 1'b0, 9'h000, 1'b0, 1'b1, 2'd2}; // bad mnem 15
      tbl[18] = '{4'd6, 4'd5, 4'd2, 4'd12, 3'd0, 1'b0, 9'h000, 1'b0, 1'b1, 2'd1}; // ADD rd=12

      // Reset state
      do_reset();
      chk("rst_we", imem_we, 0);      chk("rst_addr", imem_addr, 0);
      chk("rst_wdata", imem_wdata, 0); chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);       chk("rst_err", err, 0);
      chk("rst_code", err_code, 0);   chk("rst_count", count, 0);
      chk("rst_ready", in_ready, 0);  chk("rst_s_count", s_count, 0);

      // Single-instruction vectors
      for (int i = 0; i < NV; i++) begin
         do_reset();
         start_load(8'h10);
         set_in(tbl[i].mnem, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm);
         in_valid = 1'b1;
         cyc();
         in_valid = 1'b0;
         chk($sformatf("v%0d_we", i), imem_we, tbl[i].we);
         if (tbl[i].we) begin
            chk($sformatf("v%0d_wdata", i), imem_wdata, tbl[i].wdata);
            chk($sformatf("v%0d_addr", i), imem_addr, 8'h10);
         end
         chk($sformatf("v%0d_count", i), count, {8'd0, tbl[i].we});
         chk($sformatf("v%0d_done", i), done, tbl[i].done);
         chk($sformatf("v%0d_err", i), err, tbl[i].err);
         chk($sformatf("v%0d_code", i), err_code, tbl[i].code);
         chk($sformatf("v%0d_ready", i), in_ready, tbl[i].we & ~tbl[i].done);
      end

      // Back-to-back program ending in HALT
      do_reset();
      start_load(8'h10);
      in_valid = 1'b1;
      set_in(4'd0, 4'd4, 4'd3, 4'd0, 3'd0); cyc();
      chk("b2b0_we", imem_we, 1); chk("b2b0_addr", imem_addr, 8'h10); chk("b2b0_wdata", imem_wdata, 9'h00C);
      set_in(4'd8, 4'd3, 4'd6, 4'd0, 3'd0); cyc();
      chk("b2b1_we", imem_we, 1); chk("b2b1_addr", imem_addr, 8'h11); chk("b2b1_wdata", imem_wdata, 9'h11E);
      set_in(4'd7, 4'd7, 4'd0, 4'd1, 3'd2); cyc();
      chk("b2b2_we", imem_we, 1); chk("b2b2_addr", imem_addr, 8'h12); chk("b2b2_wdata", imem_wdata, 9'h0F9);
      set_in(4'd9, 4'd0, 4'd0, 4'd0, 3'd0); cyc();
      chk("b2b3_we", imem_we, 1); chk("b2b3_addr", imem_addr, 8'h13); chk("b2b3_wdata", imem_wdata, 9'h1C0);
      chk("b2b3_done", done, 1); chk("b2b3_busy", busy, 0); chk("b2b3_ready", in_ready, 0);
      chk("b2b3_count", count, 4);
      cyc();
      in_valid = 1'b0;
      chk("b2b_after_we", imem_we, 0); chk("b2b_after_count", count, 4);

      // Error, then restart clears it; start during LOAD is ignored
      do_reset();
      start_load(8'h10);
      set_in(4'd6, 4'd5, 4'd2, 4'd3, 3'd0); in_valid = 1'b1; cyc(); in_valid = 1'b0;
      chk("rs_err", err, 1); chk("rs_code", err_code, 1); chk("rs_we", imem_we, 0);
      start_load(8'h20);
      chk("rs2_err", err, 0); chk("rs2_busy", busy, 1); chk("rs2_count", count, 0);
      chk("rs2_code", err_code, 0);
      set_in(4'd4, 4'd4, 4'd1, 4'd0, 3'd0); in_valid = 1'b1; cyc(); in_valid = 1'b0;
      chk("rs3_addr", imem_addr, 8'h20);
      start_load(8'h40);
      set_in(4'd4, 4'd4, 4'd1, 4'd0, 3'd0); in_valid = 1'b1; cyc(); in_valid = 1'b0;
      chk("ign_addr", imem_addr, 8'h21); chk("ign_count", count, 2);

      // Memory full on the small instance: base 2, SW, SW -> FULL
      do_reset();
      s_base_addr = 2'd2; s_start = 1'b1; cyc(); s_start = 1'b0;
      s_in_mnem = 4'd5; s_in_rs = 4'd6; s_in_rt = 4'd1; s_in_valid = 1'b1;
      cyc();
      chk("full0_we", s_imem_we, 1); chk("full0_addr", s_imem_addr, 2);
      chk("full0_wdata", s_imem_wdata, 9'h065); chk("full0_err", s_err, 0);
      cyc();
      s_in_valid = 1'b0;
      chk("full1_we", s_imem_we, 1); chk("full1_addr", s_imem_addr, 3);
      chk("full1_wdata", s_imem_wdata, 9'h065); chk("full1_err", s_err, 1);
      chk("full1_code", s_err_code, 3); chk("full1_ready", s_in_ready, 0);
      chk("full1_count", s_count, 2);
      cyc();
      chk("full2_we", s_imem_we, 0);

      // HALT in the last slot takes precedence over FULL
      s_start = 1'b1; cyc(); s_start = 1'b0;
      chk("hl_busy", s_busy, 1); chk("hl_err", s_err, 0);
      s_in_mnem = 4'd5; s_in_valid = 1'b1; cyc();
      s_in_mnem = 4'd9; cyc();
      s_in_valid = 1'b0;
      chk("hl_we", s_imem_we, 1); chk("hl_addr", s_imem_addr, 3);
      chk("hl_wdata", s_imem_wdata, 9'h1C0); chk("hl_done", s_done, 1);
      chk("hl_err2", s_err, 0); chk("hl_code", s_err_code, 0);

      // Reset asserted during a transfer cycle
      do_reset();
      start_load(8'h10);
      set_in(4'd6, 4'd5, 4'd2, 4'd9, 3'd0); in_valid = 1'b1;
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mr_we", imem_we, 0);   chk("mr_addr", imem_addr, 0);
      chk("mr_wdata", imem_wdata, 0); chk("mr_busy", busy, 0);
      chk("mr_count", count, 0);  chk("mr_ready", in_ready, 0);
      chk("mr_err", err, 0);      chk("mr_done", done, 0);
      rst_n = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk("mr_idle_we", imem_we, 0); chk("mr_idle_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
